joybus_device: RTL and testbench
================================

JOYBUS_DEVICE -- requirements
Module: joybus_device

Interface
REQ-001 Parameter LEVEL_WIDTH, default 2: sample_clk cycles per line level; bit cell is BIT_WIDTH = 4*LEVEL_WIDTH cycles.
REQ-002 Parameter IDLE_BITS, default 2: frame ends after IDLE_BITS*BIT_WIDTH cycles of continuous high.
REQ-003 Parameter TURN_CYCLES, default 16: cycles from cmd_valid to the first TX level.
REQ-004 Parameter DEVICE_ID, default 16'h0500: first two bytes of the info response.
REQ-005 sample_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset; asynchronous and active-low.
REQ-007 data_rx  in  1  asynchronous Joybus line sample.
REQ-008 data_tx  out  1  value driven when data_oe=1.
REQ-009 data_oe  out  1  1 = drive line; 0 = line released (Z).
REQ-010 buttons  in  32  status response payload, MSB first.
REQ-011 pak_status  in  8  third byte of the info response.
REQ-012 cmd_byte  out  8  last decoded command; valid while cmd_valid=1.
REQ-013 cmd_valid  out  1  one-cycle pulse per well-formed frame.
REQ-014 reset_cmd  out  1  one-cycle pulse, coincident with cmd_valid, when cmd_byte=8'hFF.
REQ-015 frame_err  out  1  one-cycle pulse on a malformed or aborted frame.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 data_rx SHALL pass through a 2-flop synchroniser; all RX timing is measured on the synchronised value.
REQ-018 States SHALL be IDLE, RX_LOW, RX_HIGH, TURNAROUND, TX_BIT, TX_STOP.
REQ-019 IDLE→RX_LOW on a falling edge; the low-time counter clears.
REQ-020 RX_LOW→RX_HIGH on a rising edge: bit = 1 if low time < 2*LEVEL_WIDTH, else 0; shift bit in MSB first; increment the received-bit count (saturates at 63).
REQ-021 RX_HIGH→RX_LOW on a falling edge; RX_HIGH→frame end once the high time reaches IDLE_BITS*BIT_WIDTH.
REQ-022 At frame end, a well-formed frame has exactly 9 bits: 8 command bits plus the console stop bit, which is decoded as a 1. Any other count pulses frame_err and returns to IDLE.
REQ-023 For a well-formed frame, cmd_valid pulses for one cycle; buttons and pak_status are latched in that same cycle.
REQ-024 cmd 8'h00/8'hFF SHALL respond with 3 bytes {DEVICE_ID, pak_status}. cmd 8'h01 SHALL respond with 4 bytes, the latched buttons value. Any other cmd gets no response and returns to IDLE.
REQ-025 TURNAROUND lasts TURN_CYCLES cycles; a falling edge on data_rx during TURNAROUND aborts the response, pulses frame_err and enters RX_LOW.
REQ-026 TX_BIT: data_oe=1, bytes MSB first. Each bit is 4 levels of LEVEL_WIDTH cycles: logical 0 = L,L,L,H; logical 1 = L,H,H,H.
REQ-027 TX_STOP: L,L,H levels, then data_oe=0 and the state returns to IDLE. Total TX length = (8*nbytes+1)*BIT_WIDTH - LEVEL_WIDTH cycles.
REQ-028 data_rx edges SHALL be ignored from TX_BIT entry until one cycle after TX_STOP exit (own-echo).
REQ-029 When data_oe=0, data_tx SHALL be 1.

Reset
REQ-030 While reset_n=0: state=IDLE, data_oe=0, data_tx=1, cmd_byte=8'h00, cmd_valid=reset_cmd=frame_err=busy=0, all counters 0. These values apply immediately, without waiting for a clock edge.
REQ-031 Reset asserted mid-transmit SHALL release the line immediately; no partial stop bit follows.

Configuration
REQ-032 Macro JOYBUS_RX_GLITCH_FILTER_EN, when defined: a level change on the synchronised data_rx is accepted only after 2 consecutive equal samples. This adds 1 cycle of RX latency; single-cycle glitches produce no edge.
REQ-033 Without JOYBUS_RX_GLITCH_FILTER_EN: every change on the synchronised value is an edge.

Structure
REQ-034 Package joybus_pkg SHALL hold the command codes (CMD_INFO=8'h00, CMD_STATUS=8'h01, CMD_RESET=8'hFF), the state enum, and the level-pattern constants.
REQ-035 Sub-module joybus_rx_filter SHALL contain the synchroniser, the optional glitch filter, and edge detection; it outputs rx_level, rx_fall and rx_rise.

Verification
REQ-036 Console sends 8'h00 plus stop bit, pak_status=8'h01 → cmd_valid with cmd_byte=8'h00; TX bytes 05 00 01 plus controller stop bit; data_oe low afterwards.
REQ-037 Console sends 8'h01, buttons=32'h8000_7F81 → TX 80 00 7F 81 plus stop; bit timings exactly 8 cycles at LEVEL_WIDTH=2.
REQ-038 Console sends 8'hFF → reset_cmd and cmd_valid pulse in the same cycle; info response follows.
REQ-039 7-bit frame, or command 8'h02 → frame_err pulse (7-bit case) or no response (8'h02); data_oe stays 0.
REQ-040 reset_n driven low at the 10th TX bit → data_oe=0 asynchronously, busy=0; the next 8'h01 frame gets a full response.
REQ-041 With JOYBUS_RX_GLITCH_FILTER_EN, a 1-cycle low glitch during IDLE → no RX_LOW entry and no frame_err; without the macro → frame_err.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared definitions for the Joybus device: command codes, FSM state
// encoding and the per-bit line-level patterns used by the transmitter.
// No ports.
package joybus_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    // Level sequences, first level in the MSB. The stop pattern has only
    // three meaningful levels (L,L,H); its LSB is never used.
    localparam logic [3:0] LVL_ZERO = 4'b0001;
    localparam logic [3:0] LVL_ONE  = 4'b0111;
    localparam logic [3:0] LVL_STOP = 4'b0010;

    typedef enum logic [2:0] {
        IDLE,
        RX_LOW,
        RX_HIGH,
        TURNAROUND,
        TX_BIT,
        TX_STOP
    } state_t;

    function automatic logic level_value(input logic [3:0] pattern, input logic [1:0] idx);
        return pattern[2'd3 - idx];
    endfunction

endpackage

// File: rtl/joybus_rx_filter.sv
// Joybus receive front end: 2-flop synchroniser, optional glitch filter
// and edge detection on the synchronised line.
// Macro JOYBUS_RX_GLITCH_FILTER_EN: when defined, a new level is accepted
// only after two consecutive equal samples (one extra cycle of latency).
// Ports:
//   sample_clk  in   clock
//   reset_n     in   async active-low reset
//   data_rx     in   raw asynchronous line sample
//   rx_level    out  filtered line level
//   rx_fall     out  one-cycle pulse on a high->low change
//   rx_rise     out  one-cycle pulse on a low->high change
module joybus_rx_filter (
    input  logic sample_clk,
    input  logic reset_n,
    input  logic data_rx,
    output logic rx_level,
    output logic rx_fall,
    output logic rx_rise
);

    logic sync1;
    logic sync2;
    logic level_q;
    logic level_d;

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
    logic sync3;

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) sync3 <= 1'b1;
        else          sync3 <= sync2;
    end

    assign level_d = (sync2 == sync3) ? sync2 : level_q;
`else
    assign level_d = sync2;
`endif

    // Line idles high, so every stage resets to 1 to avoid a false edge.
    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1   <= data_rx;
            sync2   <= sync1;
            level_q <= level_d;
        end
    end

    assign rx_level = level_d;
    assign rx_fall  = level_q & ~level_d;
    assign rx_rise  = ~level_q & level_d;

endmodule

// File: rtl/joybus_device.sv
// Joybus (N64-style) controller device: receives a one-byte console
// command, then answers info (00/FF) or status (01) requests on the same
// open-drain line.
// Macro JOYBUS_RX_GLITCH_FILTER_EN enables the receive glitch filter.
// Ports:
//   sample_clk  in   clock
//   reset_n     in   async active-low reset
//   data_rx     in   line sample
//   data_tx     out  driven level (1 while released)
//   data_oe     out  1 = drive the line
//   buttons     in   32-bit status payload
//   pak_status  in   third info byte
//   cmd_byte    out  last decoded command
//   cmd_valid   out  pulse per well-formed frame
//   reset_cmd   out  pulse with cmd_valid for command FF
//   frame_err   out  pulse on malformed or aborted frame
//   busy        out  state is not IDLE
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | line idle, waiting for a console falling edge
// RX_LOW     | measuring the low part of a received bit
// RX_HIGH    | measuring high time; long high ends the frame
// TURNAROUND | gap before the response; console edge aborts
// TX_BIT     | driving response bits, MSB first
// TX_STOP    | driving the controller stop bit, then release
module joybus_device
    import joybus_pkg::*;
#(
    parameter int          LEVEL_WIDTH = 2,
    parameter int          IDLE_BITS   = 2,
    parameter int          TURN_CYCLES = 16,
    parameter logic [15:0] DEVICE_ID   = 16'h0500
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        data_rx,
    output logic        data_tx,
    output logic        data_oe,
    input  logic [31:0] buttons,
    input  logic [7:0]  pak_status,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        reset_cmd,
    output logic        frame_err,
    output logic        busy
);

    // low_cnt holds (low time - 1) when the rise arrives, so a bit is 1
    // when low_cnt < 2*LEVEL_WIDTH - 1.
    localparam logic [15:0] LOW_ONE_MAX = 16'(2 * LEVEL_WIDTH - 1);
    // high_cnt holds (high time - 2) in the cycle it is compared.
    localparam logic [15:0] HIGH_END    = 16'(IDLE_BITS * 4 * LEVEL_WIDTH - 2);
    localparam logic [15:0] TURN_LAST   = 16'(TURN_CYCLES - 1);
    localparam logic [15:0] LVL_LAST    = 16'(LEVEL_WIDTH - 1);

    state_t      state;
    logic        rx_level;
    logic        rx_fall;
    logic        rx_rise;
    logic [15:0] low_cnt;
    logic [15:0] high_cnt;
    logic [15:0] turn_cnt;
    logic [15:0] lvl_cnt;
    logic [1:0]  lvl_idx;
    logic [5:0]  bit_cnt;
    logic [5:0]  tx_bits_left;
    logic [8:0]  rx_sh;
    logic [31:0] tx_sh;
    logic        echo_mask;

    joybus_rx_filter u_rx_filter (
        .sample_clk (sample_clk),
        .reset_n    (reset_n),
        .data_rx    (data_rx),
        .rx_level   (rx_level),
        .rx_fall    (rx_fall),
        .rx_rise    (rx_rise)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge sample_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            data_oe      <= 1'b0;
            data_tx      <= 1'b1;
            cmd_byte     <= 8'h00;
            cmd_valid    <= 1'b0;
            reset_cmd    <= 1'b0;
            frame_err    <= 1'b0;
            low_cnt      <= '0;
            high_cnt     <= '0;
            turn_cnt     <= '0;
            lvl_cnt      <= '0;
            lvl_idx      <= '0;
            bit_cnt      <= '0;
            tx_bits_left <= '0;
            rx_sh        <= '0;
            tx_sh        <= '0;
            echo_mask    <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            reset_cmd <= 1'b0;
            frame_err <= 1'b0;
            echo_mask <= 1'b0;
            case (state)
                IDLE: begin
                    // First idle cycle after our own stop bit still sees our echo.
                    if (rx_fall && !echo_mask) begin
                        state   <= RX_LOW;
                        low_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                RX_LOW: begin
                    if (rx_rise) begin
                        rx_sh    <= {rx_sh[7:0], (low_cnt < LOW_ONE_MAX)};
                        if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
                        high_cnt <= '0;
                        state    <= RX_HIGH;
                    end else if (!rx_level && low_cnt != 16'hFFFF) begin
                        low_cnt <= low_cnt + 16'd1;
                    end
                end
                RX_HIGH: begin
                    if (rx_fall) begin
                        low_cnt <= '0;
                        state   <= RX_LOW;
                    end else if (high_cnt >= HIGH_END) begin
                        if (bit_cnt != 6'd9) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cmd_valid <= 1'b1;
                            cmd_byte  <= rx_sh[8:1];
                            reset_cmd <= (rx_sh[8:1] == CMD_RESET);
                            turn_cnt  <= TURN_LAST;
                            case (rx_sh[8:1])
                                CMD_INFO, CMD_RESET: begin
                                    tx_sh        <= {DEVICE_ID, pak_status, 8'h00};
                                    tx_bits_left <= 6'd24;
                                    state        <= TURNAROUND;
                                end
                                CMD_STATUS: begin
                                    tx_sh        <= buttons;
                                    tx_bits_left <= 6'd32;
                                    state        <= TURNAROUND;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end else begin
                        high_cnt <= high_cnt + 16'd1;
                    end
                end
                TURNAROUND: begin
                    if (rx_fall) begin
                        frame_err <= 1'b1;
                        low_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= RX_LOW;
                    end else if (turn_cnt == 16'd0) begin
                        data_oe <= 1'b1;
                        data_tx <= 1'b0;
                        lvl_cnt <= LVL_LAST;
                        lvl_idx <= 2'd0;
                        state   <= TX_BIT;
                    end else begin
                        turn_cnt <= turn_cnt - 16'd1;
                    end
                end
                TX_BIT: begin
                    if (lvl_cnt != 16'd0) begin
                        lvl_cnt <= lvl_cnt - 16'd1;
                    end else begin
                        lvl_cnt <= LVL_LAST;
                        if (lvl_idx != 2'd3) begin
                            lvl_idx <= lvl_idx + 2'd1;
                            data_tx <= level_value(tx_sh[31] ? LVL_ONE : LVL_ZERO, lvl_idx + 2'd1);
                        end else begin
                            lvl_idx <= 2'd0;
                            data_tx <= 1'b0;
                            tx_sh   <= {tx_sh[30:0], 1'b0};
                            if (tx_bits_left == 6'd1) state <= TX_STOP;
                            else tx_bits_left <= tx_bits_left - 6'd1;
                        end
                    end
                end
                TX_STOP: begin
                    if (lvl_cnt != 16'd0) begin
                        lvl_cnt <= lvl_cnt - 16'd1;
                    end else begin
                        lvl_cnt <= LVL_LAST;
                        if (lvl_idx != 2'd2) begin
                            lvl_idx <= lvl_idx + 2'd1;
                            data_tx <= level_value(LVL_STOP, lvl_idx + 2'd1);
                        end else begin
                            lvl_idx   <= 2'd0;
                            data_oe   <= 1'b0;
                            data_tx   <= 1'b1;
                            echo_mask <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_joybus_device.sv
// Directed self-checking bench for joybus_device (defaults: LEVEL_WIDTH=2,
// BIT_WIDTH=8, IDLE_BITS=2, TURN_CYCLES=16). The shared line is modelled as
// an open-drain wire pulled high: the device drives it when data_oe=1,
// otherwise the console driver sets it.
module tb_joybus_device;

    localparam int TURN = 16;

    logic        sample_clk;
    logic        reset_n;
    logic        con_drive;
    logic [31:0] buttons;
    logic [7:0]  pak_status;
    logic        data_tx;
    logic        data_oe;
    logic [7:0]  cmd_byte;
    logic        cmd_valid;
    logic        reset_cmd;
    logic        frame_err;
    logic        busy;
    wire         line = data_oe ? data_tx : con_drive;

    int total = 0;
    int bad   = 0;

    joybus_device #(
        .LEVEL_WIDTH (2),
        .IDLE_BITS   (2),
        .TURN_CYCLES (TURN),
        .DEVICE_ID   (16'h0500)
    ) dut (
        .sample_clk (sample_clk),
        .reset_n    (reset_n),
        .data_rx    (line),
        .data_tx    (data_tx),
        .data_oe    (data_oe),
        .buttons    (buttons),
        .pak_status (pak_status),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .reset_cmd  (reset_cmd),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial sample_clk = 1'b0;
    always #5 sample_clk = ~sample_clk;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic con_level(input logic v, input int n);
        con_drive = v;
        repeat (n) @(negedge sample_clk);
    endtask

    task automatic send_bit(input logic b);
        con_level(1'b0, b ? 2 : 6);
        con_level(1'b1, b ? 6 : 2);
    endtask

    task automatic send_frame(input logic [7:0] c, input int nbits, input bit stop);
        for (int i = 0; i < nbits; i++) send_bit(c[7 - i]);
        if (stop) begin
            con_level(1'b0, 2);
            con_level(1'b1, 2);
        end
    endtask

    // sel: 0 = cmd_valid, 1 = frame_err, 2 = data_oe. n = cycles, -1 on timeout.
    task automatic wait_for(input int sel, input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge sample_clk); #1;
            if ((sel == 0 && cmd_valid) || (sel == 1 && frame_err) || (sel == 2 && data_oe)) begin
                n = c;
                return;
            end
        end
    endtask

    task automatic run_cmd(input logic [7:0] c, input bit exp_tx, input string tag);
        int n;
        send_frame(c, 8, 1);
        wait_for(0, 100, n);
        check(n > 0, 1, {tag, "_cmdv_seen"});
        check(cmd_byte, c, {tag, "_cmd_byte"});
        check(reset_cmd, c == 8'hFF, {tag, "_reset_cmd"});
        check(busy, exp_tx, {tag, "_busy_at_cmdv"});
        // Inputs change after the latch edge; the response must not follow.
        buttons    = ~buttons;
        pak_status = ~pak_status;
        @(posedge sample_clk); #1;
        check(cmd_valid, 0, {tag, "_cmdv_width"});
        check(reset_cmd, 0, {tag, "_rstcmd_width"});
        if (exp_tx) begin
            wait_for(2, 40, n);
            check(n, TURN - 1, {tag, "_turnaround"});
        end else begin
            wait_for(2, 80, n);
            check(n, -1, {tag, "_no_response"});
            check(busy, 0, {tag, "_idle_after"});
        end
    endtask

    // Samples each TX bit as 8 cycles, then the 6-cycle stop bit.
    task automatic rx_response(input logic [31:0] exp, input int nbits, input int abort_bit,
                               input string tag);
        logic [7:0] w;
        logic [5:0] s;
        int         oe_drop;
        oe_drop = 0;
        for (int i = 0; i < nbits; i++) begin
            w = '0;
            for (int k = 0; k < 8; k++) begin
                if (!data_oe) oe_drop++;
                w = {w[6:0], data_tx};
                if (i == abort_bit && k == 3) begin
                    #2 reset_n = 1'b0;
                    #1;
                    check(data_oe, 0, {tag, "_rst_oe"});
                    check(data_tx, 1, {tag, "_rst_tx"});
                    check(busy, 0, {tag, "_rst_busy"});
                    check(cmd_byte, 8'h00, {tag, "_rst_cmd_byte"});
                    return;
                end
                @(posedge sample_clk); #1;
            end
            check(w, exp[31 - i] ? 8'h3F : 8'h03, $sformatf("%s_bit%0d", tag, i));
        end
        s = '0;
        for (int k = 0; k < 6; k++) begin
            if (!data_oe) oe_drop++;
            s = {s[4:0], data_tx};
            @(posedge sample_clk); #1;
        end
        check(s, 6'b000011, {tag, "_stop"});
        check(oe_drop, 0, {tag, "_oe_held"});
        check(data_oe, 0, {tag, "_oe_released"});
        check(data_tx, 1, {tag, "_tx_idle_high"});
        check(busy, 0, {tag, "_busy_end"});
    endtask

    initial begin
        int n;
        con_drive  = 1'b1;
        buttons    = 32'h0;
        pak_status = 8'h0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        check(data_oe, 0, "reset_oe");
        check(data_tx, 1, "reset_tx");
        check(cmd_byte, 8'h00, "reset_cmd_byte");
        check(cmd_valid, 0, "reset_cmdv");
        check(reset_cmd, 0, "reset_rstcmd");
        check(frame_err, 0, "reset_ferr");
        check(busy, 0, "reset_busy");
        repeat (3) @(negedge sample_clk);
        reset_n = 1'b1;
        repeat (5) @(negedge sample_clk);

        // Info request
        pak_status = 8'h01;
        run_cmd(8'h00, 1, "info");
        rx_response({16'h0500, 8'h01, 8'h00}, 24, -1, "info");
        repeat (5) @(negedge sample_clk);

        // Status request
        buttons = 32'h8000_7F81;
        run_cmd(8'h01, 1, "status");
        rx_response(32'h8000_7F81, 32, -1, "status");
        repeat (5) @(negedge sample_clk);

        // Reset command: info response with current pak status
        pak_status = 8'hA5;
        run_cmd(8'hFF, 1, "rstcmd");
        rx_response({16'h0500, 8'hA5, 8'h00}, 24, -1, "rstcmd");
        repeat (5) @(negedge sample_clk);

        // 7-bit frame
        send_frame(8'hA5, 7, 0);
        wait_for(1, 60, n);
        check(n > 0, 1, "short_ferr");
        check(data_oe, 0, "short_oe");
        @(posedge sample_clk); #1;
        check(busy, 0, "short_idle");
        check(frame_err, 0, "short_ferr_width");
        repeat (5) @(negedge sample_clk);

        // Unknown command
        run_cmd(8'h02, 0, "unknown");
        repeat (5) @(negedge sample_clk);

        // Console edge during turnaround aborts the response
        send_frame(8'h00, 8, 1);
        wait_for(0, 100, n);
        check(n > 0, 1, "abort_cmdv_seen");
        repeat (4) @(negedge sample_clk);
        con_drive = 1'b0;
        wait_for(1, 10, n);
        check(n > 0, 1, "abort_ferr");
        check(busy, 1, "abort_rx_low");
        check(data_oe, 0, "abort_oe");
        con_level(1'b0, 2);
        con_level(1'b1, 2);
        wait_for(1, 40, n);
        check(n > 0, 1, "abort_tail_ferr");
        check(data_oe, 0, "abort_tail_oe");
        repeat (5) @(negedge sample_clk);

        // Reset asserted during the 10th TX bit, then a full response
        buttons = 32'hDEAD_BEEF;
        run_cmd(8'h01, 1, "midrst");
        rx_response(32'hDEAD_BEEF, 32, 9, "midrst");
        repeat (3) @(negedge sample_clk);
        check(data_oe, 0, "midrst_held_oe");
        reset_n = 1'b1;
        repeat (5) @(negedge sample_clk);
        buttons = 32'h1234_5678;
        run_cmd(8'h01, 1, "after_rst");
        rx_response(32'h1234_5678, 32, -1, "after_rst");
        repeat (5) @(negedge sample_clk);

        // Single-cycle low glitch while idle
        con_drive = 1'b0;
        @(negedge sample_clk);
        con_drive = 1'b1;
        wait_for(1, 40, n);
`ifdef JOYBUS_RX_GLITCH_FILTER_EN
        check(n, -1, "glitch_filtered");
        check(busy, 0, "glitch_idle");
`else
        check(n > 0, 1, "glitch_ferr");
        check(data_oe, 0, "glitch_oe");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
